latch_vector_sequencer: RTL and testbench
=========================================

Name: latch_vector_sequencer

Overview:
- Synthesizable, clocked stimulus driver for the transparent-latch cell; the initiator side of the cell's D/E/S/R/Q interface.
- On a start request it sweeps all 16 input codes {D,E,S,R} = 0000..1111 onto the latch inputs.
- Holds each code for a programmable number of cycles and samples the latch output Q at the end of each hold.
- Collects the 16 Q samples into a result word for on-chip self-test of the latch.

Parameters:
- HOLD_CYCLES, 100, clock cycles each code is driven; legal range 2..(2^HOLD_W - 1).
- HOLD_W, 8, width of the internal hold counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  stop the sweep and return to IDLE; takes priority over start.
- lat_d  output  1  latch data input (code bit 3).
- lat_e  output  1  latch enable (code bit 2).
- lat_s  output  1  latch set (code bit 1).
- lat_r  output  1  latch reset (code bit 0).
- lat_q  input  1  latch output, sampled by this block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- result  output  16  result[k] = lat_q sampled while code k was driven.
- exp_mask  input  16  expected result word; used only with SEQ_CHECK_EN.
- mismatch_cnt  output  5  number of result bits differing from exp_mask.
- err  output  1  high when mismatch_cnt != 0.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - lat_d/e/s/r = 0, busy = 0, done = 0.
  - result = 0x0000, code = 0, hold counter = 0, mismatch_cnt = 0, err = 0.
- All outputs are registered. {lat_d,lat_e,lat_s,lat_r} always equals the registered 4-bit code while in DRIVE, and 0000 otherwise.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs 0000, busy = 0.
  - If start=1 and abort=0 at clock edge N: clear result, code = 0, hold counter = 0, go to DRIVE.
  - Code 0 and busy=1 are visible from cycle N+1.
- DRIVE:
  - The hold counter increments every cycle.
  - On the cycle where counter == HOLD_CYCLES-1, lat_q is captured into result[code] at that edge.
  - On that same edge, if code != 15: code increments, counter resets to 0, state stays DRIVE.
  - On that same edge, if code == 15: go to DONE.
  - Each code is therefore driven for exactly HOLD_CYCLES cycles.
  - Code k is first visible at cycle N+1+k*HOLD_CYCLES.
- DONE:
  - Occupies one cycle: done=1, busy=0, outputs 0000, result valid and stable.
  - Unconditionally returns to IDLE next cycle.
  - done is asserted at cycle N+1+16*HOLD_CYCLES.
- start while in DRIVE or DONE: ignored, no restart, no effect on the sweep.
- abort in DRIVE:
  - Next cycle: state IDLE, outputs 0000, busy = 0, no done pulse.
  - result keeps the bits captured before the abort; bits not yet captured keep their cleared value.
- abort in IDLE or DONE: no effect, except that abort+start in IDLE does not start a sweep.
- result holds its value until the next accepted start or reset.
- Reset asserted mid-sweep: immediately reinitialises to the reset state above; no done pulse.
- lat_q is treated as synchronous to clk. The latch response must settle within HOLD_CYCLES-1 cycles.

Optional Feature:
- Macro: SEQ_CHECK_EN
- Defined:
  - On the cycle after DONE, mismatch_cnt = popcount(result XOR exp_mask) and err = (mismatch_cnt != 0).
  - Both are registered and held until the next accepted start, which clears them; reset also clears them.
- Not defined:
  - mismatch_cnt and err are tied to 0.
  - exp_mask is unused; no compare or popcount logic is present.

Test Plan (HOLD_CYCLES=4, start accepted at edge N=0):
- Timing: lat_q tied 0 -> code k visible at cycle 1+4k; code 15 at cycle 61; done pulse at cycle 65; busy high cycles 1..64; outputs 0000 at cycle 65.
- lat_q driven from lat_d -> result = 0xFF00 at done.
- lat_q = lat_d AND lat_r -> result = 0xAA00 (codes 9, 11, 13, 15).
- start re-pulsed at cycle 10; abort at the cycle code 5 is driven -> sweep unaffected by the start; after abort, outputs 0000 and busy=0 next cycle; no done; result[4:0] captured, result[15:5] = 0.
- rst asserted during code 7 -> outputs, busy, result and state immediately at reset values; a new start runs a full clean sweep.
- SEQ_CHECK_EN defined, exp_mask = 0xAA00, lat_q = lat_d -> cycle after done: mismatch_cnt = 4, err = 1. With exp_mask = 0xFF00: mismatch_cnt = 0, err = 0.

Source files
------------

// File: rtl/latch_vector_sequencer.sv
// Sweeps all 16 {D,E,S,R} codes into a latch under test and collects Q samples.
// Optional SEQ_CHECK_EN adds a registered compare of the result against exp_mask.
module latch_vector_sequencer #(
    parameter int HOLD_CYCLES = 100,
    parameter int HOLD_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        lat_d,
    output logic        lat_e,
    output logic        lat_s,
    output logic        lat_r,
    input  logic        lat_q,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    input  logic [15:0] exp_mask,
    output logic [4:0]  mismatch_cnt,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        code;
    logic [3:0]        drv;
    logic [HOLD_W-1:0] cnt;
    logic              hold_end;
    logic              accept;

    assign hold_end = (cnt == HOLD_LAST);
    assign accept   = (state == S_IDLE) && start && !abort;

    assign {lat_d, lat_e, lat_s, lat_r} = drv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            code   <= 4'd0;
            drv    <= 4'd0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 16'h0000;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_DRIVE;
                        code   <= 4'd0;
                        drv    <= 4'd0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        result <= 16'h0000;
                    end
                end
                S_DRIVE: begin
                    // abort wins over a capture landing on the same edge
                    if (abort) begin
                        state <= S_IDLE;
                        drv   <= 4'd0;
                        busy  <= 1'b0;
                    end else if (hold_end) begin
                        result[code] <= lat_q;
                        cnt          <= '0;
                        if (code == 4'hF) begin
                            state <= S_DONE;
                            drv   <= 4'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            code <= code + 4'd1;
                            drv  <= code + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    drv   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_CHECK_EN
    logic [15:0] diff;
    logic [4:0]  pop;

    assign diff = result ^ exp_mask;

    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(diff[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= 5'd0;
            err          <= 1'b0;
        end else if (accept) begin
            mismatch_cnt <= 5'd0;
            err          <= 1'b0;
        end else if (state == S_DONE) begin
            mismatch_cnt <= pop;
            err          <= (pop != 5'd0);
        end
    end
`else
    logic unused_exp;
    assign unused_exp   = ^exp_mask;
    assign mismatch_cnt = 5'd0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_latch_vector_sequencer.sv
// Directed bench for latch_vector_sequencer at HOLD_CYCLES=4.
// Builds with or without SEQ_CHECK_EN.
module tb_latch_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        lat_d, lat_e, lat_s, lat_r;
    logic        lat_q;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] exp_mask;
    logic [4:0]  mismatch_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    latch_vector_sequencer #(
        .HOLD_CYCLES(4),
        .HOLD_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .lat_d       (lat_d),
        .lat_e       (lat_e),
        .lat_s       (lat_s),
        .lat_r       (lat_r),
        .lat_q       (lat_q),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .exp_mask    (exp_mask),
        .mismatch_cnt(mismatch_cnt),
        .err         (err)
    );

    // latch stand-in selected per test
    always_comb begin
        case (mode)
            1:       lat_q = lat_d;
            2:       lat_q = lat_d & lat_r;
            3:       lat_q = lat_r;
            default: lat_q = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lat_vec();
        return {28'd0, lat_d, lat_e, lat_s, lat_r};
    endfunction

    // full sweep from idle; c counts cycles after the accepting edge
    task automatic sweep(input int m, input logic [15:0] want_res,
                         input logic [15:0] mask, input int want_mm);
        int mm;
`ifdef SEQ_CHECK_EN
        mm = want_mm;
`else
        mm = 0;
`endif
        mode     = m;
        exp_mask = mask;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            if (c <= 64) begin
                chk("code", lat_vec(), 32'((c - 1) / 4));
                chk("busy", 32'(busy), 1);
                chk("done_lo", 32'(done), 0);
                if (c == 1) chk("mm_clr", 32'(mismatch_cnt), 0);
            end else if (c == 65) begin
                chk("done_hi", 32'(done), 1);
                chk("busy_done", 32'(busy), 0);
                chk("lat_done", lat_vec(), 0);
                chk("result", 32'(result), 32'(want_res));
            end else begin
                chk("done_end", 32'(done), 0);
                chk("mm", 32'(mismatch_cnt), 32'(mm));
                chk("err", 32'(err), 32'(mm != 0));
                chk("result_hold", 32'(result), 32'(want_res));
            end
            if (c < 66) step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        exp_mask = 16'h0000;
        #12;
        chk("rst_lat", lat_vec(), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_mm", 32'(mismatch_cnt), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // start together with abort in idle must not launch
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        step();
        chk("sa_busy2", 32'(busy), 0);

        sweep(0, 16'h0000, 16'h0001, 1);
        sweep(1, 16'hFF00, 16'hAA00, 4);
        sweep(2, 16'hAA00, 16'hAA00, 0);

        // restart attempt at cycle 10, abort while code 5 is driven
        mode  = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 22; c++) begin
            if (c == 10) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("no_restart", lat_vec(), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_lat", lat_vec(), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_result", 32'(result), 32'h000A);
        for (int i = 0; i < 8; i++) begin
            if (done) chk("abort_done", 32'(done), 0);
            step();
        end
        chk("abort_idle", 32'(busy), 0);
        chk("abort_keep", 32'(result), 32'h000A);

        // async reset while code 7 is driven
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 30; c++) step();
        chk("pre_rst_code", lat_vec(), 7);
        chk("pre_rst_res", 32'(result), 32'h002A);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lat", lat_vec(), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_result", 32'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) chk("arst_done", 32'(done), 0);
            step();
        end
        chk("arst_idle", 32'(busy), 0);

        sweep(1, 16'hFF00, 16'hFF00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1, "timeout");
    end

endmodule
